// File: rtl/and4_comb.sv
// Combinational four-operand bitwise AND, WIDTH bits wide.
// Used as the datapath core of and4 in both output modes.
module and4_comb #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] y
);

    assign y = a & b & c & d;

endmodule

// File: rtl/and4.sv
// Four-operand AND leaf with optional output register, valid strobe and
// all-ones / any-ones reduction flags taken from whatever dout presents.
module and4 #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] dina,
    input  logic [WIDTH-1:0] dinb,
    input  logic [WIDTH-1:0] dinc,
    input  logic [WIDTH-1:0] dind,
    output logic [WIDTH-1:0] dout,
    output logic             out_valid,
    output logic             all_ones,
    output logic             any_ones
);

    logic [WIDTH-1:0] and_result;

    and4_comb #(.WIDTH(WIDTH)) u_comb (
        .a (dina),
        .b (dinb),
        .c (dinc),
        .d (dind),
        .y (and_result)
    );

    generate
        if (REG_OUT) begin : g_reg
            logic [WIDTH-1:0] dout_q;
            logic             valid_q;

            // dout only loads on qualified cycles, so unknown operands
            // presented with in_valid low never reach the register.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= in_valid;
                    if (in_valid) begin
                        dout_q <= and_result;
                    end
                end
            end

            assign dout      = dout_q;
            assign out_valid = valid_q;
        end else begin : g_comb
            logic unused_clk_rst;

            assign unused_clk_rst = clk | rst;
            assign dout           = and_result;
            assign out_valid      = in_valid;
        end
    endgenerate

    assign all_ones = &dout;
    assign any_ones = |dout;

endmodule

// File: tb/tb_and4.sv
// Randomised scoreboard bench for and4: an 8-bit and a 1-bit registered
// instance plus an 8-bit combinational instance, checked against a bitwise model.
module tb_and4;

    typedef struct {
        logic       v;
        logic [7:0] d;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       v8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, c8 = '0, d8 = '0;
    logic [7:0] dout8;
    logic       ov8, all8, any8;

    logic       v1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, c1 = '0, d1 = '0;
    logic [0:0] dout1;
    logic       ov1, all1, any1;

    logic       vc = 1'b0;
    logic [7:0] ac = '0, bc = '0, cc = '0, dc = '0;
    logic [7:0] doutc;
    logic       ovc, allc, anyc;

    exp_t q8[$];
    exp_t q1[$];
    exp_t qc[$];

    logic [7:0] hold8 = '0;
    logic       hold1 = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    and4 #(.WIDTH(8), .REG_OUT(1'b1)) u_reg8 (
        .clk(clk), .rst(rst), .in_valid(v8),
        .dina(a8), .dinb(b8), .dinc(c8), .dind(d8),
        .dout(dout8), .out_valid(ov8), .all_ones(all8), .any_ones(any8)
    );

    and4 #(.WIDTH(1), .REG_OUT(1'b1)) u_reg1 (
        .clk(clk), .rst(rst), .in_valid(v1),
        .dina(a1), .dinb(b1), .dinc(c1), .dind(d1),
        .dout(dout1), .out_valid(ov1), .all_ones(all1), .any_ones(any1)
    );

    and4 #(.WIDTH(8), .REG_OUT(1'b0)) u_comb8 (
        .clk(clk), .rst(rst), .in_valid(vc),
        .dina(ac), .dinb(bc), .dinc(cc), .dind(dc),
        .dout(doutc), .out_valid(ovc), .all_ones(allc), .any_ones(anyc)
    );

    // A result bit is set exactly when all four operands carry a one there.
    function automatic logic [7:0] and_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            int n;
            n = int'(a[i]) + int'(b[i]) + int'(c[i]) + int'(d[i]);
            r[i] = (n == 4);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // One stimulus cycle for all three instances; expectations are queued here.
    task automatic drive(input logic r, input logic va, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d, input logic vb,
                         input logic [3:0] abcd1, input bit xop);
        exp_t e;
        @(negedge clk);
        rst = r;
        v8 = va;
        if (xop && !va) begin
            a8 = 'x; b8 = 'x; c8 = 'x; d8 = 'x;
        end else begin
            a8 = a; b8 = b; c8 = c; d8 = d;
        end
        v1 = vb;
        a1[0] = abcd1[3]; b1[0] = abcd1[2]; c1[0] = abcd1[1]; d1[0] = abcd1[0];
        vc = 1'($urandom_range(0, 1));
        ac = 8'($urandom) | 8'($urandom);
        bc = 8'($urandom) | 8'($urandom);
        cc = 8'($urandom) | 8'($urandom);
        dc = 8'($urandom) | 8'($urandom);

        if (r) begin
            hold8 = '0;
            hold1 = 1'b0;
        end else begin
            if (va) hold8 = and_model(a, b, c, d);
            if (vb) hold1 = (abcd1 == 4'hF);
        end
        e.v = !r && va; e.d = hold8;           q8.push_back(e);
        e.v = !r && vb; e.d = {7'd0, hold1};   q1.push_back(e);
        e.v = vc;       e.d = and_model(ac, bc, cc, dc); qc.push_back(e);
    endtask

    // Registered-instance monitor: one entry per clock edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q8.size() > 0) begin
                e = q8.pop_front();
                check("reg8_valid", 64'(ov8), 64'(e.v));
                check("reg8_dout", 64'(dout8), 64'(e.d));
                check("reg8_all_ones", 64'(all8), 64'(e.d == 8'hFF));
                check("reg8_any_ones", 64'(any8), 64'(e.d != 8'h00));
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("reg1_valid", 64'(ov1), 64'(e.v));
                check("reg1_dout", 64'(dout1), 64'(e.d[0]));
                check("reg1_all_ones", 64'(all1), 64'(e.d[0]));
                check("reg1_any_ones", 64'(any1), 64'(e.d[0]));
            end
        end
    end

    // Combinational-instance monitor: compares shortly after each drive.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (qc.size() > 0) begin
                e = qc.pop_front();
                check("comb_valid", 64'(ovc), 64'(e.v));
                check("comb_dout", 64'(doutc), 64'(e.d));
                check("comb_all_ones", 64'(allc), 64'(e.d == 8'hFF));
                check("comb_any_ones", 64'(anyc), 64'(e.d != 8'h00));
            end
        end
    end

    initial begin
        logic [3:0] tv[4];
        int wait_cycles;
        tv[0] = 4'b0000; tv[1] = 4'b0111; tv[2] = 4'b1001; tv[3] = 4'b1111;

        // Reset with everything high and valid: outputs must stay cleared.
        repeat (2) drive(1'b1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 4'hF, 1'b0);

        for (int i = 0; i < 4; i++)
            drive(1'b0, 1'b1, 8'hFF, 8'hF0, 8'h3C, 8'hFF, 1'b1, tv[i], 1'b0);

        for (int i = 0; i < 16; i++)
            drive(1'b0, 1'b1, 8'($urandom), 8'($urandom) | 8'hC3, 8'($urandom) | 8'h3C,
                  8'hFF, 1'b1, 4'(i), 1'b0);

        // Hold with idle zero operands on the 1-bit path, unknowns on the 8-bit path.
        repeat (3) drive(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 4'h0, 1'b1);

        drive(1'b0, 1'b1, 8'hFF, 8'hF0, 8'h3C, 8'hFF, 1'b1, 4'hF, 1'b0);
        drive(1'b0, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 4'hF, 1'b0);

        // Continuous valid stream with reset on the third cycle.
        for (int i = 0; i < 6; i++)
            drive(i == 2, 1'b1, 8'hFF, 8'hFF, 8'($urandom) | 8'h81, 8'hFF, 1'b1, 4'hF, 1'b0);

        for (int i = 0; i < 80; i++) begin
            logic [7:0] m;
            m = 8'($urandom);
            drive($urandom_range(0, 19) == 0, 1'($urandom_range(0, 1)),
                  8'($urandom) | m, 8'($urandom) | m, 8'($urandom) | m, 8'($urandom) | m,
                  1'($urandom_range(0, 1)), 4'($urandom) | 4'($urandom), 1'($urandom_range(0, 1)));
        end

        wait_cycles = 0;
        while ((q8.size() > 0 || q1.size() > 0 || qc.size() > 0) && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        repeat (2) @(posedge clk);
        check("scoreboard_drained", 64'(q8.size() + q1.size() + qc.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
